// File: rtl/lsu_periph_bridge.sv
// rtl/lsu_periph_bridge.sv - LSU to peripheral-bus bridge with pipeline stall (optional abort: PERIPH_TIMEOUT_EN)
module lsu_periph_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  be,
  input  logic        rd_req,
  input  logic        wr_req,
  output logic        stall,
  output logic [31:0] toLSU,
  output logic        p_valid,
  input  logic        p_ready,
  output logic [31:0] p_addr,
  output logic [31:0] p_wdata,
  output logic        p_we,
  output logic [3:0]  p_be,
  input  logic        p_rvalid,
  input  logic [31:0] p_rdata,
  input  logic        p_err
);

  // No-data marker: the downstream mux falls back to data-memory read data.
  localparam logic [31:0] SENT_NONE = 32'hDEAD_BEEF;
  // Failed access marker: bus error or abandoned transaction.
  localparam logic [31:0] SENT_ERR  = 32'hBABE_CAFE;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_RESP,
    S_DONE
  } state_e;

  state_e      state_q;
  logic        p_valid_q;
  logic [31:0] p_addr_q;
  logic [31:0] p_wdata_q;
  logic        p_we_q;
  logic [3:0]  p_be_q;
  logic [31:0] hold_q;
  logic        periph;
  logic        timeout_hit;

  // Any access with a non-zero address byte [15:8] targets the peripheral window.
  assign periph = (addr[15:8] != 8'h00) & (rd_req | wr_req);

`ifdef PERIPH_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CNT_W-1:0] cnt_q;

  // Counter spans REQ and RESP together; it is cleared when REQ is entered.
  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  localparam int unsigned UNUSED_TIMEOUT_CYCLES = TIMEOUT_CYCLES;
  assign timeout_hit = 1'b0;
`endif

  // Transaction FSM: latch request, handshake, capture response, one data cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      p_valid_q <= 1'b0;
      p_addr_q  <= 32'h0;
      p_wdata_q <= 32'h0;
      p_we_q    <= 1'b0;
      p_be_q    <= 4'h0;
      hold_q    <= SENT_NONE;
`ifdef PERIPH_TIMEOUT_EN
      cnt_q     <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (periph) begin
            // A simultaneous read and write is treated as a write.
            p_addr_q  <= addr;
            p_wdata_q <= wdata;
            p_we_q    <= wr_req;
            p_be_q    <= wr_req ? be : 4'hF;
            p_valid_q <= 1'b1;
            state_q   <= S_REQ;
`ifdef PERIPH_TIMEOUT_EN
            cnt_q     <= '0;
`endif
          end
        end
        S_REQ: begin
`ifdef PERIPH_TIMEOUT_EN
          cnt_q <= cnt_q + 1'b1;
`endif
          // Acceptance wins over an expiring timeout in the same cycle.
          if (p_ready) begin
            p_valid_q <= 1'b0;
            state_q   <= S_RESP;
          end else if (timeout_hit) begin
            p_valid_q <= 1'b0;
            hold_q    <= SENT_ERR;
            state_q   <= S_DONE;
          end
        end
        S_RESP: begin
`ifdef PERIPH_TIMEOUT_EN
          cnt_q <= cnt_q + 1'b1;
`endif
          if (p_rvalid) begin
            // Write acks carry no data, so a clean write reports the no-data marker.
            if (p_err) begin
              hold_q <= SENT_ERR;
            end else if (p_we_q) begin
              hold_q <= SENT_NONE;
            end else begin
              hold_q <= p_rdata;
            end
            state_q <= S_DONE;
          end else if (timeout_hit) begin
            hold_q  <= SENT_ERR;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          // The pipeline still holds the request here; it must not be reissued.
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Stall starts combinationally on the hit so the pipeline freezes in cycle 0.
  assign stall   = ((state_q == S_IDLE) & periph) | (state_q == S_REQ) | (state_q == S_RESP);
  assign toLSU   = (state_q == S_DONE) ? hold_q : SENT_NONE;
  assign p_valid = p_valid_q;
  assign p_addr  = p_addr_q;
  assign p_wdata = p_wdata_q;
  assign p_we    = p_we_q;
  assign p_be    = p_be_q;

endmodule

// File: tb/tb_lsu_periph_bridge.sv
// tb/tb_lsu_periph_bridge.sv - scoreboard bench for lsu_periph_bridge
module tb_lsu_periph_bridge;

`ifdef PERIPH_TIMEOUT_EN
  localparam int unsigned TO = 8;
`else
  localparam int unsigned TO = 64;
`endif
  localparam logic [31:0] SENT_NONE = 32'hDEAD_BEEF;
  localparam logic [31:0] SENT_ERR  = 32'hBABE_CAFE;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic        rd_req;
  logic        wr_req;
  logic        stall;
  logic [31:0] toLSU;
  logic        p_valid;
  logic        p_ready;
  logic [31:0] p_addr;
  logic [31:0] p_wdata;
  logic        p_we;
  logic [3:0]  p_be;
  logic        p_rvalid;
  logic [31:0] p_rdata;
  logic        p_err;

  int n_chk  = 0;
  int n_pass = 0;

  logic [31:0] sb[$];

  // Bus responder configuration and state.
  logic        bus_en;
  int          ready_delay;
  int          resp_delay;
  logic [31:0] rsp_data;
  logic        rsp_err;
  int          phase;
  int          wcnt;

  lsu_periph_bridge #(.TIMEOUT_CYCLES(TO)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .addr     (addr),
    .wdata    (wdata),
    .be       (be),
    .rd_req   (rd_req),
    .wr_req   (wr_req),
    .stall    (stall),
    .toLSU    (toLSU),
    .p_valid  (p_valid),
    .p_ready  (p_ready),
    .p_addr   (p_addr),
    .p_wdata  (p_wdata),
    .p_we     (p_we),
    .p_be     (p_be),
    .p_rvalid (p_rvalid),
    .p_rdata  (p_rdata),
    .p_err    (p_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // Peripheral model: accepts after ready_delay cycles of p_valid, responds resp_delay cycles later.
  initial begin
    phase = 0;
    wcnt  = 0;
    forever begin
      @(negedge clk);
      p_ready  = 1'b0;
      p_rvalid = 1'b0;
      p_err    = 1'b0;
      if (bus_en) begin
        if (phase == 0 && p_valid) begin
          if (wcnt == ready_delay) begin
            p_ready = 1'b1;
            phase   = 1;
            wcnt    = 0;
          end else wcnt++;
        end else if (phase == 1) begin
          if (wcnt == resp_delay) begin
            p_rvalid = 1'b1;
            p_rdata  = rsp_data;
            p_err    = rsp_err;
            phase    = 0;
            wcnt     = 0;
          end else wcnt++;
        end
      end
    end
  end

  task automatic access(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] b,
                        input logic rd, input logic wr, input int exp_stall,
                        input int exp_vcyc, input logic [31:0] expected);
    int  n;
    int  vcyc;
    bit  done;
    sb.push_back(expected);
    @(negedge clk);
    addr = a; wdata = wd; be = b; rd_req = rd; wr_req = wr;
    #1 chk("stall_cycle0", 32'(stall), 32'd1);
    n = 1; vcyc = 0; done = 0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(posedge clk); #1;
      if (!stall) done = 1;
      else begin
        n++;
        if (p_valid) begin
          vcyc++;
          chk("p_addr", p_addr, a);
          chk("p_we", 32'(p_we), 32'(wr));
          chk("p_be", 32'(p_be), wr ? 32'(b) : 32'hF);
          if (wr) chk("p_wdata", p_wdata, wd);
        end
      end
    end
    if (!done) chk("stall_bound", 32'd0, 32'd1);
    chk("stall_cycles", 32'(n), 32'(exp_stall));
    chk("valid_cycles", 32'(vcyc), 32'(exp_vcyc));
    chk("toLSU_done", toLSU, sb.pop_front());
    chk("p_valid_done", 32'(p_valid), 32'd0);
    @(negedge clk);
    rd_req = 1'b0; wr_req = 1'b0;
    @(posedge clk); #1;
    chk("toLSU_after", toLSU, SENT_NONE);
    chk("stall_after", 32'(stall), 32'd0);
  endtask

  task automatic set_bus(input int rdly, input int sdly, input logic [31:0] d, input logic e);
    ready_delay = rdly; resp_delay = sdly; rsp_data = d; rsp_err = e;
  endtask

  initial begin
    int cnt;
    rst_n = 1'b0; addr = 32'h0; wdata = 32'h0; be = 4'h0; rd_req = 1'b0; wr_req = 1'b0;
    p_ready = 1'b0; p_rvalid = 1'b0; p_rdata = 32'h0; p_err = 1'b0;
    bus_en = 1'b1;
    set_bus(0, 0, 32'h0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_toLSU", toLSU, SENT_NONE);
    chk("rst_p_valid", 32'(p_valid), 32'd0);
    chk("rst_p_addr", p_addr, 32'h0);
    chk("rst_p_wdata", p_wdata, 32'h0);
    chk("rst_p_we", 32'(p_we), 32'd0);
    chk("rst_p_be", 32'(p_be), 32'd0);
    @(negedge clk) rst_n = 1'b1;

    // Minimum-latency load.
    set_bus(0, 0, 32'h1234_5678, 1'b0);
    access(32'h0000_0100, 32'h0, 4'h0, 1'b1, 1'b0, 3, 1, 32'h1234_5678);

    // Store with delayed acceptance; ack data must not leak to toLSU.
    set_bus(3, 0, 32'h0000_0077, 1'b0);
    access(32'h0000_2004, 32'hA5A5_A5A5, 4'b0011, 1'b0, 1'b1, 6, 4, SENT_NONE);

    // Window miss.
    @(negedge clk);
    addr = 32'h0000_0040; rd_req = 1'b1;
    #1;
    chk("miss_stall", 32'(stall), 32'd0);
    chk("miss_toLSU", toLSU, SENT_NONE);
    repeat (3) begin
      @(posedge clk); #1;
      chk("miss_p_valid", 32'(p_valid), 32'd0);
      chk("miss_stall_hold", 32'(stall), 32'd0);
    end
    @(negedge clk) rd_req = 1'b0;

    // Error response on a load.
    set_bus(0, 0, 32'h5555_AAAA, 1'b1);
    access(32'h0000_FF00, 32'h0, 4'h0, 1'b1, 1'b0, 3, 1, SENT_ERR);

    // Read and write together is a write.
    set_bus(1, 2, 32'hCAFE_0001, 1'b0);
    access(32'h0000_0400, 32'h0BAD_F00D, 4'b1100, 1'b1, 1'b1, 6, 2, SENT_NONE);

    // Load with a slow response.
    set_bus(0, 2, 32'h89AB_CDEF, 1'b0);
    access(32'h0001_0800, 32'h0, 4'h0, 1'b1, 1'b0, 5, 1, 32'h89AB_CDEF);

    // Reset while in RESP; the later response must be ignored.
    set_bus(0, 4, 32'h1357_9BDF, 1'b0);
    @(negedge clk);
    addr = 32'h0000_0300; rd_req = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0; rd_req = 1'b0;
    #1;
    chk("mid_rst_stall", 32'(stall), 32'd0);
    chk("mid_rst_p_valid", 32'(p_valid), 32'd0);
    chk("mid_rst_toLSU", toLSU, SENT_NONE);
    chk("mid_rst_p_addr", p_addr, 32'h0);
    @(negedge clk) rst_n = 1'b1;
    repeat (6) begin
      @(posedge clk); #1;
      chk("late_rsp_toLSU", toLSU, SENT_NONE);
      chk("late_rsp_stall", 32'(stall), 32'd0);
    end
    phase = 0; wcnt = 0;

`ifdef PERIPH_TIMEOUT_EN
    // Never accepted: abort after TIMEOUT_CYCLES REQ cycles.
    bus_en = 1'b0;
    access(32'h0000_0500, 32'h0, 4'h0, 1'b1, 1'b0, 9, 8, SENT_ERR);
    bus_en = 1'b1;
`else
    // Never accepted: stall persists indefinitely.
    bus_en = 1'b0;
    @(negedge clk);
    addr = 32'h0000_0500; rd_req = 1'b1;
    cnt = 0;
    repeat (120) begin
      @(posedge clk); #1;
      if (stall) cnt++;
    end
    chk("no_timeout_stall", 32'(cnt), 32'd120);
    @(negedge clk);
    rst_n = 1'b0; rd_req = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    #1 chk("no_timeout_recover", 32'(stall), 32'd0);
    bus_en = 1'b1;
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
